pair_judge: RTL and testbench

- Downstream consumer of the two-card chooser in the memory-card game.
- Captures the two chosen card indices when the chooser flags a completed pair, and reveals both cards for a fixed hold time.
- After the hold, compares the card faces, then updates the matched-card mask, score and miss counters.
- Drives the face-up mask used by the display logic and flags end of game.

---
 rtl/pair_judge_if.sv | 30 +++
 rtl/pair_judge.sv | 135 +++++++++++++
 tb/tb_pair_judge.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pair_judge_if.sv
// Bundle of chooser-side inputs and judge results shared between the
// memory-card chooser/display side and the pair judge.
interface pair_judge_if #(
    parameter int FACE_W = 3
);
    logic [4:0]            choose_1;
    logic [4:0]            choose_2;
    logic                  C2;
    logic [16*FACE_W-1:0]  deck_faces;
    logic [15:0]           revealed;
    logic [15:0]           matched;
    logic [3:0]            score;
    logic [7:0]            misses;
    logic                  busy;
    logic                  result_valid;
    logic                  result_match;
    logic                  game_over;

    modport master (
        output choose_1, choose_2, C2, deck_faces,
        input  revealed, matched, score, misses, busy,
               result_valid, result_match, game_over
    );

    modport slave (
        input  choose_1, choose_2, C2, deck_faces,
        output revealed, matched, score, misses, busy,
               result_valid, result_match, game_over
    );
endinterface

// File: rtl/pair_judge.sv
// Pair judge for the memory-card game: latches a completed pick from the
// chooser, shows both cards for SHOW_TICKS cycles, then scores the pair.
module pair_judge #(
    parameter int SHOW_TICKS = 4,
    parameter int FACE_W     = 3
) (
    input  logic         new_clk,
    input  logic         rst,
    pair_judge_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOW    = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_reg;
    logic        c2_d_reg;
    logic [7:0]  timer_reg;
    logic [3:0]  idx_a_reg;
    logic [3:0]  idx_b_reg;
    logic [15:0] revealed_reg;
    logic [15:0] matched_reg;
    logic [3:0]  score_reg;
    logic [7:0]  misses_reg;
    logic        result_valid_reg;
    logic        result_match_reg;
    logic        game_over_reg;

    // Per-card face values unpacked from the flat deck bus.
    logic [FACE_W-1:0] faces [16];
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_face
            assign faces[gi] = bus.deck_faces[gi*FACE_W +: FACE_W];
        end
    endgenerate

    logic        c2_rise;
    logic        pick_valid;
    logic [15:0] pick_mask;
    logic [15:0] latched_mask;
    logic [15:0] matched_upd;
    logic        faces_equal;

    // Edge detect on C2 and validity of the pick currently offered.
    assign c2_rise      = bus.C2 & ~c2_d_reg;
    assign pick_valid   = ~bus.choose_1[4] & ~bus.choose_2[4]
                        & (bus.choose_1 != bus.choose_2)
                        & ~matched_reg[bus.choose_1[3:0]]
                        & ~matched_reg[bus.choose_2[3:0]];
    assign pick_mask    = (16'd1 << bus.choose_1[3:0]) | (16'd1 << bus.choose_2[3:0]);
    assign latched_mask = (16'd1 << idx_a_reg) | (16'd1 << idx_b_reg);
    assign matched_upd  = matched_reg | latched_mask;
    assign faces_equal  = (faces[idx_a_reg] == faces[idx_b_reg]);

    // Judge FSM: all outputs registered. The comparison result is captured
    // on the SHOW->RESOLVE edge so result_valid is high exactly while the
    // state is RESOLVE; the counters update on the edge leaving RESOLVE.
    always_ff @(posedge new_clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            c2_d_reg         <= 1'b0;
            timer_reg        <= 8'd0;
            idx_a_reg        <= 4'd0;
            idx_b_reg        <= 4'd0;
            revealed_reg     <= 16'd0;
            matched_reg      <= 16'd0;
            score_reg        <= 4'd0;
            misses_reg       <= 8'd0;
            result_valid_reg <= 1'b0;
            result_match_reg <= 1'b0;
            game_over_reg    <= 1'b0;
        end else begin
            c2_d_reg         <= bus.C2;
            result_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (c2_rise && pick_valid) begin
                        idx_a_reg    <= bus.choose_1[3:0];
                        idx_b_reg    <= bus.choose_2[3:0];
                        timer_reg    <= 8'(SHOW_TICKS - 1);
                        revealed_reg <= matched_reg | pick_mask;
                        state_reg    <= SHOW;
                    end
                end
                SHOW: begin
                    if (timer_reg == 8'd0) begin
                        result_valid_reg <= 1'b1;
                        result_match_reg <= faces_equal;
                        state_reg        <= RESOLVE;
                    end else begin
                        timer_reg <= timer_reg - 8'd1;
                    end
                end
                RESOLVE: begin
                    if (result_match_reg) begin
                        matched_reg  <= matched_upd;
                        score_reg    <= score_reg + 4'd1;
                        revealed_reg <= matched_upd;
                        if (matched_upd == 16'hFFFF) begin
                            game_over_reg <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        if (misses_reg != 8'hFF) begin
                            misses_reg <= misses_reg + 8'd1;
                        end
                        revealed_reg <= matched_reg;
                        state_reg    <= IDLE;
                    end
                end
                DONE: begin
                    revealed_reg  <= 16'hFFFF;
                    game_over_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.revealed     = revealed_reg;
    assign bus.matched      = matched_reg;
    assign bus.score        = score_reg;
    assign bus.misses       = misses_reg;
    assign bus.busy         = (state_reg == SHOW) || (state_reg == RESOLVE);
    assign bus.result_valid = result_valid_reg;
    assign bus.result_match = result_match_reg;
    assign bus.game_over    = game_over_reg;
endmodule

// File: tb/tb_pair_judge.sv
// Directed bench for pair_judge: a table of picks with hand-computed
// outcomes, then hand-written sequences for retrigger, reset and saturation.
module tb_pair_judge;
    localparam int S = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pair_judge_if #(.FACE_W(3)) bus ();

    pair_judge #(.SHOW_TICKS(S), .FACE_W(3)) dut (
        .new_clk (clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  c1;
        logic [4:0]  c2;
        bit          valid;
        bit          is_match;
        logic [15:0] show_mask;
        logic [15:0] matched_after;
        int          score_after;
        int          misses_after;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.C2 = 1'b0;
        bus.choose_1 = 5'd16;
        bus.choose_2 = 5'd16;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [15:0] exp_rev;
        @(negedge clk);
        bus.choose_1 = v.c1;
        bus.choose_2 = v.c2;
        bus.C2 = 1'b1;
        @(negedge clk);
        // Drop C2 and move the indices: the latched pair must be unaffected.
        bus.C2 = 1'b0;
        bus.choose_1 = 5'd15;
        bus.choose_2 = 5'd14;
        if (v.valid) begin
            for (int k = 0; k < S; k++) begin
                chk("show_revealed", 32'(bus.revealed), 32'(v.show_mask));
                chk("show_busy_rv", {30'd0, bus.busy, bus.result_valid}, 32'b10);
                @(negedge clk);
            end
            chk("result_valid", 32'(bus.result_valid), 32'd1);
            chk("result_match", 32'(bus.result_match), 32'(v.is_match));
            @(negedge clk);
        end else begin
            for (int k = 0; k < S + 2; k++) begin
                chk("invalid_busy_rv", {30'd0, bus.busy, bus.result_valid}, 32'b00);
                @(negedge clk);
            end
        end
        exp_rev = (v.matched_after == 16'hFFFF) ? 16'hFFFF : v.matched_after;
        chk("matched", 32'(bus.matched), 32'(v.matched_after));
        chk("score", 32'(bus.score), 32'(v.score_after));
        chk("misses", 32'(bus.misses), 32'(v.misses_after));
        chk("revealed_after", 32'(bus.revealed), 32'(exp_rev));
        chk("idle_flags", {29'd0, bus.busy, bus.result_valid, bus.game_over},
            {29'd0, 1'b0, 1'b0, (v.matched_after == 16'hFFFF)});
        $display("pick %0d,%0d valid=%0b match=%0b -> matched=%04h score=%0d misses=%0d",
                 v.c1, v.c2, v.valid, v.is_match, bus.matched, bus.score, bus.misses);
    endtask

    int faces_tb [16] = '{1, 2, 1, 5, 2, 0, 0, 3, 3, 5, 4, 4, 6, 6, 7, 7};

    initial begin
        int cnt;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.C2 = 1'b0;
        bus.choose_1 = 5'd16;
        bus.choose_2 = 5'd16;
        for (int i = 0; i < 16; i++) bus.deck_faces[i*3 +: 3] = 3'(faces_tb[i]);

        //          c1     c2     valid match show      matched_after score misses
        vecs[0]  = '{5'd0,  5'd1,  1'b1, 1'b0, 16'h0003, 16'h0000, 0, 1};
        vecs[1]  = '{5'd3,  5'd9,  1'b1, 1'b1, 16'h0208, 16'h0208, 1, 1};
        vecs[2]  = '{5'd4,  5'd4,  1'b0, 1'b0, 16'h0000, 16'h0208, 1, 1};
        vecs[3]  = '{5'd3,  5'd7,  1'b0, 1'b0, 16'h0000, 16'h0208, 1, 1};
        vecs[4]  = '{5'd5,  5'd16, 1'b0, 1'b0, 16'h0000, 16'h0208, 1, 1};
        vecs[5]  = '{5'd16, 5'd5,  1'b0, 1'b0, 16'h0000, 16'h0208, 1, 1};
        vecs[6]  = '{5'd1,  5'd2,  1'b1, 1'b0, 16'h020E, 16'h0208, 1, 2};
        vecs[7]  = '{5'd0,  5'd2,  1'b1, 1'b1, 16'h020D, 16'h020D, 2, 2};
        vecs[8]  = '{5'd1,  5'd4,  1'b1, 1'b1, 16'h021F, 16'h021F, 3, 2};
        vecs[9]  = '{5'd5,  5'd6,  1'b1, 1'b1, 16'h027F, 16'h027F, 4, 2};
        vecs[10] = '{5'd7,  5'd8,  1'b1, 1'b1, 16'h03FF, 16'h03FF, 5, 2};
        vecs[11] = '{5'd10, 5'd11, 1'b1, 1'b1, 16'h0FFF, 16'h0FFF, 6, 2};
        vecs[12] = '{5'd12, 5'd13, 1'b1, 1'b1, 16'h3FFF, 16'h3FFF, 7, 2};
        vecs[13] = '{5'd14, 5'd15, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 8, 2};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_revealed", 32'(bus.revealed), 32'd0);
        chk("reset_matched", 32'(bus.matched), 32'd0);
        chk("reset_counts", {20'd0, bus.score, bus.misses}, 32'd0);
        chk("reset_flags", {28'd0, bus.busy, bus.result_valid, bus.result_match, bus.game_over}, 32'd0);

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // Game over: further picks change nothing.
        @(negedge clk);
        bus.choose_1 = 5'd0;
        bus.choose_2 = 5'd1;
        for (int k = 0; k < 6; k++) begin
            bus.C2 = ~bus.C2;
            @(negedge clk);
            chk("done_flags", {29'd0, bus.game_over, bus.busy, bus.result_valid}, 32'b100);
            chk("done_revealed", 32'(bus.revealed), 32'hFFFF);
        end
        chk("done_score", 32'(bus.score), 32'd8);
        $display("done: further pulses ignored, score=%0d", bus.score);

        // C2 held high for 20 cycles: one result only.
        do_reset();
        @(negedge clk);
        bus.choose_1 = 5'd0;
        bus.choose_2 = 5'd1;
        bus.C2 = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.result_valid) cnt++;
        end
        bus.C2 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.result_valid) cnt++;
        end
        chk("hold_one_result", 32'(cnt), 32'd1);
        chk("hold_misses", 32'(bus.misses), 32'd1);
        $display("hold C2: results=%0d misses=%0d", cnt, bus.misses);

        // C2 toggled during SHOW with another pick: dropped, not queued.
        @(negedge clk);
        bus.choose_1 = 5'd0;
        bus.choose_2 = 5'd1;
        bus.C2 = 1'b1;
        cnt = 0;
        @(negedge clk);
        bus.choose_1 = 5'd2;
        bus.choose_2 = 5'd3;
        bus.C2 = 1'b0;
        @(negedge clk);
        bus.C2 = 1'b1;
        @(negedge clk);
        bus.C2 = 1'b0;
        chk("toggle_latched", 32'(bus.revealed), 32'h0003);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.result_valid) cnt++;
        end
        chk("toggle_one_result", 32'(cnt), 32'd1);
        chk("toggle_misses", 32'(bus.misses), 32'd2);
        $display("toggle C2 in SHOW: results=%0d misses=%0d", cnt, bus.misses);

        // Reset in the 2nd SHOW cycle discards the pending pair.
        do_reset();
        @(negedge clk);
        bus.choose_1 = 5'd3;
        bus.choose_2 = 5'd9;
        bus.C2 = 1'b1;
        @(negedge clk);
        bus.C2 = 1'b0;
        chk("pre_reset_show", 32'(bus.revealed), 32'h0208);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_revealed", 32'(bus.revealed), 32'd0);
        chk("midreset_flags", {30'd0, bus.busy, bus.result_valid}, 32'd0);
        chk("midreset_counts", {20'd0, bus.score, bus.misses}, 32'd0);
        cnt = 0;
        for (int k = 0; k < S + 4; k++) begin
            @(negedge clk);
            if (bus.result_valid) cnt++;
        end
        chk("midreset_no_result", 32'(cnt), 32'd0);
        chk("midreset_matched", 32'(bus.matched), 32'd0);
        $display("reset mid-SHOW: results=%0d matched=%04h", cnt, bus.matched);

        // 260 forced mismatches: misses saturates at 255.
        do_reset();
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            bus.choose_1 = 5'd0;
            bus.choose_2 = 5'd1;
            bus.C2 = 1'b1;
            @(negedge clk);
            bus.C2 = 1'b0;
            repeat (S + 2) @(negedge clk);
            if (i == 0)   chk("sat_first", 32'(bus.misses), 32'd1);
            if (i == 253) chk("sat_254", 32'(bus.misses), 32'd254);
            if (i == 254) chk("sat_255", 32'(bus.misses), 32'd255);
            $display("mismatch %0d: misses=%0d", i, bus.misses);
        end
        chk("sat_final", 32'(bus.misses), 32'd255);
        chk("sat_score", 32'(bus.score), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
